// File: rtl/fifo_rd_unpacker.sv
// ---------------------------------------------------------------------------
// fifo_rd_unpacker
//
// Read-side consumer of the async FIFO, living entirely in the FIFO read
// clock domain. Pops DATA_W-bit words whenever the FIFO is non-empty and
// there is room, splits each word into N = DATA_W/OUT_W slices and emits
// them LSB slice first on a valid/ready stream. A one-word prefetch slot
// (nxt) covers the one-cycle FIFO read latency, so a non-empty FIFO and an
// always-ready sink produce one slice per cycle with no bubbles.
//
// Ports
//   r_clk        FIFO read clock
//   r_rstn       async active-low reset
//   fifo_empty   FIFO empty flag
//   fifo_r_en    FIFO read enable (never high while empty or in reset)
//   fifo_r_data  FIFO read data, valid the cycle after fifo_r_en
//   out_data     current slice
//   out_valid    slice available
//   out_ready    sink accepts slice
//   out_last     current slice is the last slice of its word
//   word_cnt     number of words fully emitted (wraps)
// ---------------------------------------------------------------------------
module fifo_rd_unpacker #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              r_clk,
    input  logic              r_rstn,
    input  logic              fifo_empty,
    output logic              fifo_r_en,
    input  logic [DATA_W-1:0] fifo_r_data,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int N     = DATA_W / OUT_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    generate
        if ((DATA_W % OUT_W) != 0 || N < 2) begin : g_bad_param
            $error("fifo_rd_unpacker: DATA_W must be a multiple of OUT_W with at least 2 slices");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] buf_q,       buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0] nxt_q,       nxt_d;
    logic              nxt_valid_q, nxt_valid_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic              rd_pending_q;
    logic [CNT_W-1:0]  word_cnt_q,  word_cnt_d;

    // ------------------------------------------------------------------
    // Read issue
    // ------------------------------------------------------------------
    // Occupancy counts words held plus the one in flight from the FIFO,
    // taken before anything is consumed this cycle. Capping at 2 means an
    // arriving word always has a slot to land in, so no ready->read path
    // is needed.
    logic [1:0] occ;
    assign occ = {1'b0, buf_valid_q} + {1'b0, nxt_valid_q} + {1'b0, rd_pending_q};

    // r_rstn gates the enable directly: while reset holds, the cleared
    // state would otherwise look like an empty pipeline asking for data.
    assign fifo_r_en = r_rstn && !fifo_empty && (occ < 2'd2);

    // ------------------------------------------------------------------
    // Slice output
    // ------------------------------------------------------------------
    logic [N-1:0][OUT_W-1:0] slices;
    assign slices = buf_q;

    assign out_valid = buf_valid_q;
    assign out_data  = buf_valid_q ? slices[idx_q] : '0;
    assign out_last  = buf_valid_q && (idx_q == IDX_LAST);
    assign word_cnt  = word_cnt_q;

    logic xfer;
    logic last_xfer;
    assign xfer      = buf_valid_q && out_ready;
    assign last_xfer = xfer && (idx_q == IDX_LAST);   // buf is freed

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        nxt_d       = nxt_q;
        nxt_valid_d = nxt_valid_q;
        idx_d       = idx_q;
        word_cnt_d  = word_cnt_q;

        if (xfer) begin
            if (idx_q == IDX_LAST) begin
                idx_d      = '0;
                word_cnt_d = word_cnt_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Freed buf is refilled from the prefetch slot when it holds a word.
        if (last_xfer) begin
            buf_valid_d = nxt_valid_q;
            nxt_valid_d = 1'b0;
            if (nxt_valid_q) begin
                buf_d = nxt_q;
            end
        end

        // Arrival lands in buf when buf is (or is becoming) empty with
        // nothing queued ahead of it; otherwise it goes to nxt. When a free
        // coincides with a full nxt, nxt has just moved into buf above and
        // the new word refills nxt.
        if (rd_pending_q) begin
            if (!buf_valid_q || (last_xfer && !nxt_valid_q)) begin
                buf_d       = fifo_r_data;
                buf_valid_d = 1'b1;
            end else begin
                nxt_d       = fifo_r_data;
                nxt_valid_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            nxt_q        <= '0;
            nxt_valid_q  <= 1'b0;
            idx_q        <= '0;
            rd_pending_q <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            nxt_q        <= nxt_d;
            nxt_valid_q  <= nxt_valid_d;
            idx_q        <= idx_d;
            rd_pending_q <= fifo_r_en;
            word_cnt_q   <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_unpacker
//
// Directed bench for fifo_rd_unpacker with a behavioural 1-cycle-latency
// FIFO in front. The DUT is built with a 4-bit word counter so the wrap
// boundary (all-ones, then zero) is reached within a short run.
// ---------------------------------------------------------------------------
module tb_fifo_rd_unpacker;

    localparam int DATA_W = 32;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 4;
    localparam int NCAP   = 256;

    logic              r_clk = 1'b0;
    logic              r_rstn;
    logic              fifo_empty;
    logic              fifo_r_en;
    logic [DATA_W-1:0] fifo_r_data;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [CNT_W-1:0]  word_cnt;

    fifo_rd_unpacker #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .r_clk       (r_clk),
        .r_rstn      (r_rstn),
        .fifo_empty  (fifo_empty),
        .fifo_r_en   (fifo_r_en),
        .fifo_r_data (fifo_r_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .word_cnt    (word_cnt)
    );

    always #5 r_clk = ~r_clk;

    // ---------------- FIFO model ----------------
    logic [DATA_W-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    initial fifo_r_data = '0;
    always @(posedge r_clk) begin
        if (fifo_r_en) begin
            fifo_r_data <= mem[rd_ptr % 256];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [DATA_W-1:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // ---------------- Monitor ----------------
    int            cyc = 0;
    logic [7:0]    cap_d    [0:NCAP-1];
    logic          cap_last [0:NCAP-1];
    int            cap_cyc  [0:NCAP-1];
    int            ncap = 0;
    int            emp_viol = 0;
    int            rst_viol = 0;

    always @(posedge r_clk) cyc <= cyc + 1;

    // Records transfers that will complete at the coming rising edge.
    always @(negedge r_clk) begin
        if (fifo_r_en && fifo_empty) emp_viol <= emp_viol + 1;
        if (!r_rstn && fifo_r_en)    rst_viol <= rst_viol + 1;
        if (r_rstn && out_valid && out_ready && ncap < NCAP) begin
            cap_d[ncap]    <= out_data;
            cap_last[ncap] <= out_last;
            cap_cyc[ncap]  <= cyc;
            ncap           <= ncap + 1;
        end
    end

    // ---------------- Checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Returns just after the rising edge that completes transfer n.
    task automatic wait_caps(input int n);
        int k;
        k = 0;
        while (ncap < n && k < 200) begin
            @(posedge r_clk); #1;
            k = k + 1;
        end
        if (ncap < n) chk("timeout", 32'(ncap), 32'(n));
    endtask

    task automatic tick();
        @(posedge r_clk); #1;
    endtask

    initial begin
        int ren_cyc;
        int base;
        logic [7:0] exp_bytes [0:11];

        r_rstn    = 1'b0;
        out_ready = 1'b1;

        // ---- reset with a word waiting in the FIFO ----
        push(32'hDDCCBBAA);
        repeat (3) begin
            @(negedge r_clk);
            chk("rst_fifo_nonempty", 32'(fifo_empty), 32'd0);
            chk("rst_r_en",      32'(fifo_r_en), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data",  32'(out_data),  32'd0);
            chk("rst_out_last",  32'(out_last),  32'd0);
            chk("rst_word_cnt",  32'(word_cnt),  32'd0);
        end
        tick();
        r_rstn = 1'b1;

        // ---- single word ----
        @(negedge r_clk);
        ren_cyc = cyc;
        chk("sw_first_r_en", 32'(fifo_r_en), 32'd1);
        wait_caps(4);
        chk("sw_b0", 32'(cap_d[0]), 32'hAA);
        chk("sw_b1", 32'(cap_d[1]), 32'hBB);
        chk("sw_b2", 32'(cap_d[2]), 32'hCC);
        chk("sw_b3", 32'(cap_d[3]), 32'hDD);
        chk("sw_latency", 32'(cap_cyc[0] - ren_cyc), 32'd2);
        for (int i = 1; i < 4; i++) chk("sw_gap", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd1);
        chk("sw_last_pattern", {28'd0, cap_last[3], cap_last[2], cap_last[1], cap_last[0]}, 32'h8);
        chk("sw_word_cnt", 32'(word_cnt), 32'd1);

        // ---- streaming three words ----
        push(32'h03020100);
        push(32'h07060504);
        push(32'h0B0A0908);
        wait_caps(16);
        for (int i = 0; i < 12; i++) chk("st_byte", 32'(cap_d[4+i]), 32'(i));
        for (int i = 5; i < 16; i++) chk("st_gap", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd1);
        for (int i = 4; i < 16; i++) chk("st_last", 32'(cap_last[i]), 32'(((i - 4) % 4) == 3));
        chk("st_word_cnt", 32'(word_cnt), 32'd4);

        // ---- backpressure on slice BB ----
        push(32'hDDCCBBAA);
        push(32'h44332211);
        push(32'h88776655);
        wait_caps(17);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge r_clk);
            chk("bp_hold_data",  32'(out_data),  32'hBB);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_last",  32'(out_last),  32'd0);
            chk("bp_r_en_sat",   32'(fifo_r_en), 32'd0);
            chk("bp_fifo_nonempty", 32'(fifo_empty), 32'd0);
        end
        tick();
        out_ready = 1'b1;
        wait_caps(28);
        exp_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22,
                      8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 12; i++) chk("bp_byte", 32'(cap_d[16+i]), 32'(exp_bytes[i]));
        repeat (6) tick();
        chk("bp_no_extra", 32'(ncap), 32'd28);
        chk("bp_word_cnt", 32'(word_cnt), 32'd7);

        // ---- counter wrap: words 8..16 ----
        for (int i = 0; i < 9; i++) push(32'h5000_0000 + 32'(i));
        wait_caps(60);
        chk("wrap_all_ones", 32'(word_cnt), 32'hF);
        wait_caps(64);
        chk("wrap_zero", 32'(word_cnt), 32'h0);
        chk("wrap_b0_last_word", 32'(cap_d[60]), 32'h08);

        // ---- reset mid-word ----
        push(32'hDDCCBBAA);
        push(32'h0F0E0D0C);
        push(32'h13121110);
        wait_caps(66);
        chk("mr_pre_b", 32'(cap_d[65]), 32'hBB);
        r_rstn = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_out_data",  32'(out_data),  32'd0);
        chk("mr_out_last",  32'(out_last),  32'd0);
        chk("mr_word_cnt",  32'(word_cnt),  32'd0);
        chk("mr_r_en",      32'(fifo_r_en), 32'd0);
        repeat (2) tick();
        r_rstn = 1'b1;
        base = ncap;
        wait_caps(base + 4);
        for (int i = 0; i < 4; i++) chk("mr_resume", 32'(cap_d[base+i]), 32'h10 + 32'(i));
        chk("mr_resume_last", 32'(cap_last[base+3]), 32'd1);
        chk("mr_word_cnt_after", 32'(word_cnt), 32'd1);

        repeat (4) tick();
        chk("r_en_while_empty", 32'(emp_viol), 32'd0);
        chk("r_en_in_reset",    32'(rst_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_unpacker.md
# fifo_rd_unpacker

Read-side consumer of the 32-bit asynchronous FIFO, running entirely in the FIFO's read clock domain. It pops words whenever the FIFO is non-empty, splits each into `DATA_W/OUT_W` slices, and emits them LSB-slice first on a valid/ready stream. A one-word prefetch slot hides the FIFO read latency, so a non-empty FIFO and an always-ready sink give one slice per cycle with no bubbles.

## Interface
Parameters:
- `DATA_W`, default 32: FIFO word width. Must be an integer multiple of `OUT_W`.
- `OUT_W`, default 8: output slice width. `N = DATA_W/OUT_W` must be ≥ 2.
- `CNT_W`, default 16: width of the word counter.

Ports:
- `r_clk`, input, 1: single clock, the FIFO read clock.
- `r_rstn`, input, 1: asynchronous, active-low reset.
- `fifo_empty`, input, 1: FIFO empty flag.
- `fifo_r_en`, output, 1: FIFO read enable.
- `fifo_r_data`, input, `DATA_W`: FIFO read data. Valid in the cycle after `fifo_r_en` is sampled high.
- `out_data`, output, `OUT_W`: current slice.
- `out_valid`, output, 1: slice available.
- `out_ready`, input, 1: sink accepts the slice.
- `out_last`, output, 1: the current slice is slice `N-1` of its word.
- `word_cnt`, output, `CNT_W`: count of words fully emitted. Wraps.

## Operation
Storage:
- `buf`: current word, with `buf_valid` and slice index `idx` (0..N-1).
- `nxt`: prefetched word, with `nxt_valid`.
- `rd_pending`: registered copy of `fifo_r_en`. It marks read data arriving this cycle.

Occupancy and read issue:
- `occ = buf_valid + nxt_valid + rd_pending`, evaluated before any consumption this cycle.
- `fifo_r_en = !fifo_empty && occ < 2`. This is combinational from registered state and `fifo_empty` only; it does not depend on `out_ready`.
- `fifo_r_en` is never asserted while `fifo_empty = 1`.

Slice output:
- `out_valid = buf_valid`.
- `out_data = buf[idx*OUT_W +: OUT_W]`.
- `out_last = buf_valid && idx == N-1`.
- A transfer occurs on any cycle with `out_valid && out_ready`.
- On a transfer with `idx < N-1`: `idx` increments.
- On a transfer with `idx == N-1`: `idx` returns to 0, `word_cnt` increments modulo 2^CNT_W, and `buf` is freed.

Arrival (`rd_pending = 1`), `fifo_r_data` is captured at the end of the cycle:
- If `buf` is not valid, or `buf` is being freed this cycle while `nxt` is empty, the data goes to `buf`.
- Otherwise the data goes to `nxt`.

Buffer refill when `buf` is freed:
- If `nxt_valid`, then `buf <= nxt` and `nxt_valid` clears.
- This happens unless an arrival refills `nxt` in the same cycle.

Simultaneous free, arrival and `nxt_valid`:
- `buf <= nxt`, `nxt <= fifo_r_data`, and both valid flags remain set.
- `occ < 2` before consumption makes this case unreachable. It is still implemented exactly as stated.

Backpressure:
- While `out_valid && !out_ready`, `out_data`, `out_last` and `idx` hold stable.
- `out_valid` never drops without a transfer, except on reset.

Reset, asynchronous on `r_rstn` low:
- `fifo_r_en` = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `word_cnt` = 0.
- `buf_valid`, `nxt_valid`, `rd_pending` and `idx` all clear.
- Reset mid-operation discards held words and any in-flight read. Data popped from the FIFO but not emitted is lost; this is intended.
- `fifo_r_en` stays 0 while reset is asserted.

## Timing
- Cycle c: `fifo_r_en` = 1.
- Cycle c+1: `rd_pending` = 1 and `fifo_r_data` is captured at the end of the cycle.
- Cycle c+2 (earliest): `out_valid` = 1 with slice 0.
- Latency from the first read enable to the first slice is 2 cycles.
- Steady state with `fifo_empty = 0` and `out_ready = 1`:
  - One slice per cycle, `out_last` every N-th cycle.
  - `fifo_r_en` asserts once per N cycles.
  - No idle cycle between words.
- `word_cnt` updates at the edge that completes the transfer of slice `N-1`. The new value is visible in the following cycle.

## Test plan
- **Reset values.** Assert `r_rstn` = 0 with `fifo_empty` = 0 → all outputs 0 and `fifo_r_en` = 0 throughout reset.
- **Single word.** FIFO holds 0xDDCCBBAA, `out_ready` = 1 → slices AA, BB, CC, DD on consecutive cycles starting 2 cycles after `fifo_r_en`; `out_last` only on DD; then `word_cnt` = 1.
- **Streaming.** FIFO holds 0x03020100, 0x07060504, 0x0B0A0908, `out_ready` = 1 → 12 bytes 0x00..0x0B back-to-back with no gaps; `fifo_r_en` is never high while `fifo_empty` = 1; `word_cnt` = 3.
- **Backpressure.** Drop `out_ready` for 5 cycles while slice 0xBB is presented → `out_data` holds 0xBB; occupancy saturates at 2 (`fifo_r_en` stays 0); no byte is lost or duplicated.
- **Counter wrap.** Preload a sequence of 65536 words → `word_cnt` reads 0xFFFF after word 65535 and wraps to 0x0000 after word 65536.
- **Reset mid-word.** Assert reset after slice BB of 0xDDCCBBAA with `nxt` valid → outputs clear immediately; after release, output resumes with the next word still in the FIFO, at slice 0.
